// File: rtl/sb_tx_scheduler.sv
// Sideband message scheduler: queues LTSM requests and issues one beat per message to the SB transmitter.
// Push-to-beat latency 2 cycles; beats spaced PACE_CYCLES (2x after payload) so the transmitter buffer cannot overflow.
package SB_codex_pkg;
    typedef logic [7:0] SB_msg_t;
endpackage

module sb_tx_scheduler
    import SB_codex_pkg::*;
#(
    parameter int REQ_DEPTH   = 4,
    parameter int PACE_CYCLES = 12
) (
    input  logic                         clk_100MHz,
    input  logic                         reset,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  SB_msg_t                      req_msg_i,
    input  logic                         req_has_data_i,
    input  logic [63:0]                  req_data_i,
    input  logic                         sb_enable_i,
    input  logic                         send_next_flag_i,
    output SB_msg_t                      SB_msg_o,
    output logic [63:0]                  dataBus_o,
    output logic                         valid_o,
    output logic                         enable_o,
    output logic [$clog2(REQ_DEPTH):0]   fifo_count_o,
    output logic                         busy_o
);

    localparam int AW = $clog2(REQ_DEPTH);
    localparam int CW = $clog2(2 * PACE_CYCLES);
    localparam logic [AW:0]   DEPTH_C     = (AW + 1)'(REQ_DEPTH);
    localparam logic [CW-1:0] PACE_SHORT  = CW'(PACE_CYCLES - 1);
    localparam logic [CW-1:0] PACE_LONG   = CW'(2 * PACE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_PACE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_pace_ctr;

    SB_msg_t         r_msg_mem  [REQ_DEPTH];
    logic            r_has_mem  [REQ_DEPTH];
    logic [63:0]     r_data_mem [REQ_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    SB_msg_t         r_msg;
    logic [63:0]     r_data;
    logic            r_valid;
    logic            r_enable;

    logic            w_empty;
    logic            w_ready;
    logic            w_push;
    logic            w_slot;
    logic            w_fire;
    logic            w_head_has;

    assign w_empty    = (r_count == '0);
    assign w_ready    = (r_count < DEPTH_C);
    assign w_push     = req_valid_i && w_ready;
    assign w_head_has = r_has_mem[r_rd_ptr];

    // The last PACE cycle doubles as an issue slot so spacing is exactly the pace length.
    always_comb begin
        w_slot = 1'b0;
        w_fire = 1'b0;
        if (!w_empty) begin
            w_slot = (r_state == S_ISSUE) || ((r_state == S_PACE) && (r_pace_ctr == '0));
        end
        w_fire = w_slot && sb_enable_i && send_next_flag_i;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_fire) w_state_nxt = S_PACE;
            end
            S_PACE: begin
                if (r_pace_ctr == '0) begin
                    if (w_empty)      w_state_nxt = S_IDLE;
                    else if (w_fire)  w_state_nxt = S_PACE;
                    else              w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_pace_ctr <= '0;
        end else if (w_fire) begin
            r_pace_ctr <= w_head_has ? PACE_LONG : PACE_SHORT;
        end else if ((r_state == S_PACE) && (r_pace_ctr != '0)) begin
            r_pace_ctr <= r_pace_ctr - CW'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (w_push) begin
            r_msg_mem[r_wr_ptr]  <= req_msg_i;
            r_has_mem[r_wr_ptr]  <= req_has_data_i;
            r_data_mem[r_wr_ptr] <= req_data_i;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_msg    <= '0;
            r_data   <= '0;
            r_enable <= 1'b0;
        end else begin
            r_valid  <= w_fire;
            r_enable <= sb_enable_i;
            if (w_fire) begin
                r_msg  <= r_msg_mem[r_rd_ptr];
                r_data <= w_head_has ? r_data_mem[r_rd_ptr] : 64'd0;
            end
        end
    end

    assign req_ready_o  = w_ready;
    assign SB_msg_o     = r_msg;
    assign dataBus_o    = r_data;
    assign valid_o      = r_valid;
    assign enable_o     = r_enable;
    assign fifo_count_o = r_count;
    assign busy_o       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Directed bench for sb_tx_scheduler: beat timing, ordering, pacing, gating and reset behaviour.
module tb_sb_tx_scheduler;
    import SB_codex_pkg::*;

    logic        clk_100MHz;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    SB_msg_t     req_msg_i;
    logic        req_has_data_i;
    logic [63:0] req_data_i;
    logic        sb_enable_i;
    logic        send_next_flag_i;
    SB_msg_t     SB_msg_o;
    logic [63:0] dataBus_o;
    logic        valid_o;
    logic        enable_o;
    logic [2:0]  fifo_count_o;
    logic        busy_o;

    sb_tx_scheduler #(.REQ_DEPTH(4), .PACE_CYCLES(12)) dut (
        .clk_100MHz       (clk_100MHz),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_msg_i        (req_msg_i),
        .req_has_data_i   (req_has_data_i),
        .req_data_i       (req_data_i),
        .sb_enable_i      (sb_enable_i),
        .send_next_flag_i (send_next_flag_i),
        .SB_msg_o         (SB_msg_o),
        .dataBus_o        (dataBus_o),
        .valid_o          (valid_o),
        .enable_o         (enable_o),
        .fifo_count_o     (fifo_count_o),
        .busy_o           (busy_o)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int b2b;
    int busy_fall;
    logic prev_valid;
    logic prev_busy;
    int          beat_cyc [$];
    SB_msg_t     beat_msg [$];
    logic [63:0] beat_dat [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; observe 1ns later and log any beat with the edge index it appeared on.
    task automatic step();
        @(posedge clk_100MHz);
        #1;
        if (valid_o) begin
            beat_cyc.push_back(cyc);
            beat_msg.push_back(SB_msg_o);
            beat_dat.push_back(dataBus_o);
            if (prev_valid) b2b++;
        end
        if (prev_busy && !busy_o) busy_fall = cyc;
        prev_valid = valid_o;
        prev_busy  = busy_o;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input SB_msg_t m, input logic has, input logic [63:0] d);
        req_valid_i    = 1'b1;
        req_msg_i      = m;
        req_has_data_i = has;
        req_data_i     = d;
        step();
        req_valid_i    = 1'b0;
        req_data_i     = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req_valid_i = 1'b0;
        step();
        step();
        reset = 1'b0;
        beat_cyc.delete();
        beat_msg.delete();
        beat_dat.delete();
        cyc        = 0;
        b2b        = 0;
        busy_fall  = -1;
        prev_valid = 1'b0;
        prev_busy  = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        req_valid_i      = 1'b0;
        req_msg_i        = '0;
        req_has_data_i   = 1'b0;
        req_data_i       = '0;
        sb_enable_i      = 1'b1;
        send_next_flag_i = 1'b1;
        cyc = 0;

        // Reset state and single no-payload message
        do_reset();
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_msg",   64'(SB_msg_o), 64'd0);
        check("rst_data",  dataBus_o, 64'd0);
        check("rst_count", 64'(fifo_count_o), 64'd0);
        check("rst_busy",  64'(busy_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        push(8'h11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_count", 64'(fifo_count_o), 64'd1);
        run_to(30);
        check("t1_nbeats", 64'(beat_cyc.size()), 64'd1);
        check("t1_cyc",    64'(beat_cyc[0]), 64'd2);
        check("t1_msg",    64'(beat_msg[0]), 64'h11);
        check("t1_data",   beat_dat[0], 64'd0);
        check("t1_busyfall", 64'(busy_fall), 64'd14);
        check("t1_enable", 64'(enable_o), 64'd1);

        // Three back-to-back messages
        do_reset();
        push(8'hA1, 1'b0, 64'h1);
        push(8'hA2, 1'b0, 64'h2);
        push(8'hA3, 1'b0, 64'h3);
        run_to(40);
        check("t2_nbeats", 64'(beat_cyc.size()), 64'd3);
        check("t2_cyc0", 64'(beat_cyc[0]), 64'd2);
        check("t2_cyc1", 64'(beat_cyc[1]), 64'd14);
        check("t2_cyc2", 64'(beat_cyc[2]), 64'd26);
        check("t2_msg0", 64'(beat_msg[0]), 64'hA1);
        check("t2_msg1", 64'(beat_msg[1]), 64'hA2);
        check("t2_msg2", 64'(beat_msg[2]), 64'hA3);
        check("t2_count", 64'(fifo_count_o), 64'd0);
        check("t2_b2b", 64'(b2b), 64'd0);

        // Payload message doubles the pacing
        do_reset();
        push(8'h22, 1'b1, 64'hDEAD_BEEF_0123_4567);
        push(8'h33, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA);
        run_to(50);
        check("t3_nbeats", 64'(beat_cyc.size()), 64'd2);
        check("t3_cyc0",  64'(beat_cyc[0]), 64'd2);
        check("t3_data0", beat_dat[0], 64'hDEAD_BEEF_0123_4567);
        check("t3_cyc1",  64'(beat_cyc[1]), 64'd26);
        check("t3_msg1",  64'(beat_msg[1]), 64'h33);
        check("t3_data1", beat_dat[1], 64'd0);

        // Fill FIFO with sideband disabled, fifth push dropped
        sb_enable_i = 1'b0;
        do_reset();
        push(8'h41, 1'b0, 64'h0);
        push(8'h42, 1'b0, 64'h0);
        push(8'h43, 1'b0, 64'h0);
        push(8'h44, 1'b0, 64'h0);
        check("t4_ready", 64'(req_ready_o), 64'd0);
        check("t4_count", 64'(fifo_count_o), 64'd4);
        push(8'h55, 1'b0, 64'h0);
        check("t4_count5", 64'(fifo_count_o), 64'd4);
        check("t4_enable0", 64'(enable_o), 64'd0);
        check("t4_nobeat", 64'(beat_cyc.size()), 64'd0);
        sb_enable_i = 1'b1;
        run_to(70);
        check("t4_nbeats", 64'(beat_cyc.size()), 64'd4);
        check("t4_cyc0", 64'(beat_cyc[0]), 64'd5);
        check("t4_cyc3", 64'(beat_cyc[3]), 64'd41);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_msg%0d", i), 64'(beat_msg[i]), 64'h41 + 64'(i));
        check("t4_enable1", 64'(enable_o), 64'd1);

        // send_next low for 5 cycles at pace expiry
        do_reset();
        push(8'h61, 1'b0, 64'h0);
        push(8'h62, 1'b0, 64'h0);
        run_to(14);
        send_next_flag_i = 1'b0;
        repeat (5) step();
        send_next_flag_i = 1'b1;
        run_to(40);
        check("t5_nbeats", 64'(beat_cyc.size()), 64'd2);
        check("t5_cyc1", 64'(beat_cyc[1]), 64'd19);
        check("t5_msg1", 64'(beat_msg[1]), 64'h62);
        check("t5_count", 64'(fifo_count_o), 64'd0);

        // Reset during PACE with two queued requests
        do_reset();
        push(8'h71, 1'b0, 64'h0);
        push(8'h72, 1'b1, 64'h5);
        push(8'h73, 1'b0, 64'h0);
        run_to(5);
        check("t6_pre_count", 64'(fifo_count_o), 64'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_count", 64'(fifo_count_o), 64'd0);
        check("t6_valid", 64'(valid_o), 64'd0);
        check("t6_msg",   64'(SB_msg_o), 64'd0);
        check("t6_data",  dataBus_o, 64'd0);
        check("t6_busy",  64'(busy_o), 64'd0);
        check("t6_enable", 64'(enable_o), 64'd0);
        run_to(40);
        check("t6_nbeats", 64'(beat_cyc.size()), 64'd1);
        push(8'h74, 1'b0, 64'h0);
        step();
        step();
        check("t6_newbeat", 64'(beat_cyc.size()), 64'd2);
        check("t6_newmsg",  64'(beat_msg[1]), 64'h74);
        check("t6_b2b", 64'(b2b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
